// File: rtl/dfm_pkg.sv
// Shared defaults and types for the measure result path.
// Imported by the write arbiter and its round-robin helper.
package dfm_pkg;

  localparam int N_CH_DEF   = 5;
  localparam int DATA_W_DEF = 64;

  typedef logic [DATA_W_DEF-1:0] meas_data_t;
  typedef logic [2:0]            ch_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches last+1, last+2, ... modulo N for the first request.
module rr_arbiter #(
  parameter  int N  = 5,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          gnt_vld_o,
  output logic [IW-1:0] gnt_idx_o
);

  always_comb begin
    int j;
    j         = 0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last_i) + i) % N;
      if (!gnt_vld_o && req_i[j]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/meas_wr_arbiter.sv
// Serialises per-channel measure results into one regfile write port.
// One-deep holding slot per channel, round-robin issue, sticky overruns.
module meas_wr_arbiter
  import dfm_pkg::*;
#(
  parameter  int N_CH   = N_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_CH-1:0]              meas_vld_i,
  input  logic [N_CH-1:0][DATA_W-1:0]  meas_data_i,
  input  logic                         ovf_clr_i,
  output logic                         reg_wr_en_o,
  output logic [DATA_W-1:0]            reg_wr_data_o,
  output logic [CH_W-1:0]              reg_wr_ch_o,
  output logic [N_CH-1:0]              ovf_o,
  output logic                         busy_o
);

  logic [N_CH-1:0]             pend_q, pend_d;
  logic [N_CH-1:0][DATA_W-1:0] hold_q, hold_d;
  logic [CH_W-1:0]             last_q, last_d;
  logic                        wr_en_q, wr_en_d;
  logic [DATA_W-1:0]           wr_data_q, wr_data_d;
  logic [CH_W-1:0]             wr_ch_q, wr_ch_d;
  logic [N_CH-1:0]             ovf_q, ovf_d;
  logic                        busy_q, busy_d;

  logic                        gnt_vld;
  logic [CH_W-1:0]             gnt_idx;
  logic [N_CH-1:0]             gnt_oh;

  rr_arbiter #(.N(N_CH)) u_rr (
    .req_i     (pend_q),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    gnt_oh = '0;
    for (int c = 0; c < N_CH; c++) begin
      gnt_oh[c] = gnt_vld && (gnt_idx == CH_W'(c));
    end
  end

  // A strobe on the granted channel reloads the slot; not an overrun.
  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    ovf_d  = ovf_clr_i ? '0 : ovf_q;
    for (int c = 0; c < N_CH; c++) begin
      if (meas_vld_i[c]) begin
        hold_d[c] = meas_data_i[c];
        pend_d[c] = 1'b1;
        if (pend_q[c] && !gnt_oh[c]) begin
          ovf_d[c] = 1'b1;
        end
      end else if (gnt_oh[c]) begin
        pend_d[c] = 1'b0;
      end
    end
    busy_d = |pend_d;
  end

  always_comb begin
    wr_en_d   = gnt_vld;
    wr_data_d = wr_data_q;
    wr_ch_d   = wr_ch_q;
    last_d    = last_q;
    if (gnt_vld) begin
      wr_data_d = hold_q[gnt_idx];
      wr_ch_d   = gnt_idx;
      last_d    = gnt_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      hold_q    <= '0;
      last_q    <= CH_W'(N_CH - 1);
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_ch_q   <= '0;
      ovf_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_ch_q   <= wr_ch_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign reg_wr_en_o   = wr_en_q;
  assign reg_wr_data_o = wr_data_q;
  assign reg_wr_ch_o   = wr_ch_q;
  assign ovf_o         = ovf_q;
  assign busy_o        = busy_q;

endmodule

// File: doc/meas_wr_arbiter.md
Name: meas_wr_arbiter

Overview:
- Collects 64-bit result pulses from the N_CH parallel measure channels and serialises them into the single regfile write port.
- Replaces the ad-hoc one-hot case mux in the top level, which drops results when two channels finish in the same cycle.
- Each channel has a one-deep holding slot; a round-robin arbiter issues at most one registered regfile write per cycle.
- Sits between the measure array (upstream) and the regfile write port (downstream).

Parameters:
- N_CH, 5, number of measure channels.
- DATA_W, 64, result width.
- CH_W, $clog2(N_CH) (3 at default), channel index width; derived, not overridden.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high (the one clock is clk_i).
- meas_vld_i  in  N_CH  per-channel single-cycle result strobe.
- meas_data_i  in  [N_CH][DATA_W]  per-channel result; sampled only when its strobe is high.
- ovf_clr_i  in  1  clears all sticky overrun flags.
- reg_wr_en_o  out  1  regfile write strobe, one cycle per write.
- reg_wr_data_o  out  DATA_W  write data; valid while reg_wr_en_o is high.
- reg_wr_ch_o  out  CH_W  source channel of the current write.
- ovf_o  out  N_CH  sticky per-channel overrun flags.
- busy_o  out  1  high while any holding slot is pending.

Behaviour:
- Reset, asynchronous while rst_i is high:
  - pend, hold_data, reg_wr_en_o, reg_wr_data_o, reg_wr_ch_o, ovf_o and busy_o all go to 0.
  - The round-robin pointer last goes to N_CH-1, so the first search starts at channel 0.
  - Reset mid-operation discards every pending result; nothing is written after rst_i deasserts.
- Capture, per channel c, at each clk_i edge:
  - meas_vld_i[c]=1: hold_data[c] <= meas_data_i[c] and pend[c] <= 1.
  - Otherwise, if c is granted this cycle: pend[c] <= 0.
- Arbitration (combinational on the registered pend):
  - Grant the first pending channel found searching last+1, last+2, ... modulo N_CH.
  - At most one grant per cycle; no grant when pend is 0.
- Output (registered):
  - On a grant g: reg_wr_en_o <= 1, reg_wr_data_o <= hold_data[g], reg_wr_ch_o <= g, last <= g.
  - No grant: reg_wr_en_o <= 0, data and channel hold their previous values, last unchanged.
- Latency:
  - A strobe in cycle t, with no contention, gives reg_wr_en_o in cycle t+2.
  - Sustained throughput is one write per cycle.
  - With k channels pending, all k are written within k consecutive cycles.
- Strobe in the same cycle as the grant of that channel:
  - The granted write carries the old hold_data.
  - The new data is loaded and pend stays 1, so the new result is issued on a later grant.
  - This case is not an overrun.
- Overrun:
  - Strobe on channel c while pend[c]=1 and c is not granted that cycle sets ovf_o[c]=1.
  - The new data overwrites the old; the old result is lost.
- ovf_clr_i clears all ovf_o bits. If an overrun occurs in the same cycle, that bit is set (set wins).
- busy_o is the registered OR of the next-state pend.
- Pointer wrap: after a grant to channel N_CH-1, the search starts at channel 0.
- No backpressure: the regfile must accept a write every cycle.

Decomposition:
- Package dfm_pkg holds:
  - N_CH_DEF = 5 and DATA_W_DEF = 64.
  - typedef meas_data_t = logic [DATA_W_DEF-1:0].
  - typedef ch_idx_t = logic [2:0].
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N] and the last-grant index.
  - Outputs: gnt_vld and gnt_idx.
  - Purely combinational and reusable.
- Holding slots, overrun logic and the output register stay in meas_wr_arbiter.

Test Plan:
- Single channel:
  - Stimulus: reset, then meas_vld_i=5'b00100 with data 64'h0000_0000_0000_1234 in cycle t.
  - Response: cycle t+2 shows reg_wr_en_o=1, data 64'h1234, ch=2; busy_o=0 afterwards; ovf_o=0.
- All channels at once:
  - Stimulus: meas_vld_i=5'b11111 with data 64'hA0..A4.
  - Response: writes in cycles t+2..t+6 in channel order 0,1,2,3,4 with matching data; no gaps; ovf_o=0.
- Round-robin fairness:
  - Stimulus: after a grant to channel 3, strobe channels 1 and 4 together.
  - Response: channel 4 is written first, then channel 1.
- Overrun:
  - Stimulus: strobe channels 0 and 1 in cycle t, then channel 1 again in cycle t+1 with 64'hBEEF.
  - Response: ovf_o[1]=1; the channel-1 write carries 64'hBEEF; the first channel-1 value is never written.
- Same-cycle grant and strobe:
  - Stimulus: re-strobe channel 2 in the exact cycle it is granted.
  - Response: no overrun; two channel-2 writes, old data then new.
- Reset mid-operation and clear:
  - Stimulus: assert rst_i with 3 slots pending.
  - Response: outputs 0 immediately, no writes after release.
  - Stimulus: ovf_clr_i together with a new overrun on channel 4.
  - Response: ovf_o[4] stays 1 and all other bits clear.
